// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative write-back cache.
// Contents:
//   state_e                  - controller states (IDLE / WBACK / ALLOCATE)
//   TAG_W, LINE_WORDS        - derived widths for the default geometry
//   calc_tag_w/calc_line_words - same derivations for any parameterisation
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WBACK,
        ALLOCATE
    } state_e;

    localparam int unsigned TAG_W      = 32 - 6 - 3 - 2;
    localparam int unsigned LINE_WORDS = 8;

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned index_w,
                                               input int unsigned offset_w);
        return addr_w - index_w - offset_w - 2;
    endfunction

    function automatic int unsigned calc_line_words(input int unsigned offset_w);
        return 1 << offset_w;
    endfunction

endpackage

// File: rtl/line_burst.sv
// Line burst sequencer shared by write-back and allocate.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start_i      - begin a new burst at beat 0 (mem_req rises next cycle)
//   mem_ack_i    - memory beat acknowledge (ignored while mem_req_o is low)
//   mem_req_o    - beat request, held until acknowledged
//   beat_o       - current beat number
//   beat_ack_o   - current beat completes at this edge
//   done_o       - last beat completes at this edge
module line_burst #(
    parameter int unsigned OFFSET_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                mem_ack_i,
    output logic                mem_req_o,
    output logic [OFFSET_W-1:0] beat_o,
    output logic                beat_ack_o,
    output logic                done_o
);

    logic                req_q, req_d;
    logic [OFFSET_W-1:0] beat_q, beat_d;

    always_comb begin
        beat_ack_o = req_q && mem_ack_i;
        done_o     = beat_ack_o && (beat_q == '1);
        req_d      = req_q;
        beat_d     = beat_q;
        // A new start wins over completion so WBACK can chain straight into
        // ALLOCATE with mem_req staying high.
        if (start_i) begin
            req_d  = 1'b1;
            beat_d = '0;
        end else if (beat_ack_o) begin
            beat_d = beat_q + 1'b1;
            if (done_o) begin
                req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= 1'b0;
            beat_q <= '0;
        end else begin
            req_q  <= req_d;
            beat_q <= beat_d;
        end
    end

    assign mem_req_o = req_q;
    assign beat_o    = beat_q;

endmodule

// File: rtl/assoc_cache.sv
// 2-way set-associative, write-back, write-allocate cache.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   cpu_rd_en/cpu_wr_en/cpu_addr/
//   cpu_wdata                        - CPU request (held stable while stalled)
//   cpu_rdata, cpu_stall             - hit data (same cycle), access pending
//   mem_req/mem_we/mem_addr/mem_wdata- memory beat request
//   mem_ack, mem_rdata               - beat completion / read data
module assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned TAG_BITS = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
    localparam int unsigned WORDS    = calc_line_words(OFFSET_W);
    localparam int unsigned SETS     = 1 << INDEX_W;

    logic [TAG_BITS-1:0] cpu_tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic [1:0]          unused_byte_sel;

    assign cpu_tag         = cpu_addr[ADDR_W-1 -: TAG_BITS];
    assign idx             = cpu_addr[INDEX_W+OFFSET_W+1 : OFFSET_W+2];
    assign off             = cpu_addr[OFFSET_W+1 : 2];
    assign unused_byte_sel = cpu_addr[1:0];

    // Storage: data and tags unreset; valid/dirty/LRU cleared by reset.
    logic [DATA_W-1:0]   data_q  [2][SETS][WORDS];
    logic [TAG_BITS-1:0] tag_q   [2][SETS];
    logic [SETS-1:0]     valid_q [2];
    logic [SETS-1:0]     dirty_q [2];
    logic [SETS-1:0]     lru_q;

    state_e              state_q, state_d;
    logic                victim_q;
    logic [TAG_BITS-1:0] vtag_q;

    logic [1:0]          way_hit;
    logic                req, hit, miss, hit_way, vic, start;
    logic [OFFSET_W-1:0] beat;
    logic                beat_ack, done;

    line_burst #(.OFFSET_W(OFFSET_W)) u_burst (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .mem_ack_i (mem_ack),
        .mem_req_o (mem_req),
        .beat_o    (beat),
        .beat_ack_o(beat_ack),
        .done_o    (done)
    );

    always_comb begin
        way_hit[0] = valid_q[0][idx] && (tag_q[0][idx] == cpu_tag);
        way_hit[1] = valid_q[1][idx] && (tag_q[1][idx] == cpu_tag);
        req        = cpu_rd_en || cpu_wr_en;
        hit        = (state_q == IDLE) && req && (|way_hit);
        miss       = (state_q == IDLE) && req && !(|way_hit);
        hit_way    = way_hit[1];
        cpu_rdata  = data_q[hit_way][idx][off];
        cpu_stall  = req && !hit;
        if (!valid_q[0][idx]) begin
            vic = 1'b0;
        end else if (!valid_q[1][idx]) begin
            vic = 1'b1;
        end else begin
            vic = lru_q[idx];
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    start   = 1'b1;
                    state_d = (valid_q[vic][idx] && dirty_q[vic][idx]) ? WBACK : ALLOCATE;
                end
            end
            WBACK: begin
                if (done) begin
                    start   = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = (state_q == WBACK);
        mem_wdata = data_q[victim_q][idx][beat];
        if (state_q == WBACK) begin
            mem_addr = {vtag_q, idx, beat, 2'b00};
        end else begin
            mem_addr = {cpu_tag, idx, beat, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q <= state_d;
            if (hit) begin
                lru_q[idx] <= ~hit_way;
                if (cpu_wr_en) begin
                    dirty_q[hit_way][idx] <= 1'b1;
                end
            end
            // The victim is invalidated as soon as it is chosen, so a line that
            // is being refilled never looks valid until its last beat lands.
            if (miss) begin
                valid_q[vic][idx] <= 1'b0;
            end
            if ((state_q == ALLOCATE) && done) begin
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= 1'b0;
                lru_q[idx]             <= ~victim_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hit && cpu_wr_en) begin
            data_q[hit_way][idx][off] <= cpu_wdata;
        end
        if ((state_q == ALLOCATE) && beat_ack) begin
            data_q[victim_q][idx][beat] <= mem_rdata;
        end
        if ((state_q == ALLOCATE) && done) begin
            tag_q[victim_q][idx] <= cpu_tag;
        end
        if (miss) begin
            victim_q <= vic;
            vtag_q   <= tag_q[vic][idx];
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
module tb_assoc_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd_en = 1'b0, cpu_wr_en = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_stall, mem_req, mem_we;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assoc_cache #(.ADDR_W(32), .DATA_W(32), .INDEX_W(6), .OFFSET_W(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // ---------------- memory model ----------------
    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } beat_t;
    beat_t       log_q[$];
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          ack_delay = 1;
    int          hold_at   = -1;
    int          ack_total = 0;
    int          wait_cnt  = 0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    bit          prev_we;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    always @(negedge clk) begin
        if (mem_req && !rst) begin
            if (wait_cnt >= ack_delay + ((ack_total == hold_at) ? 5 : 0)) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_rd(mem_addr);
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    always @(posedge clk) begin
        if (prev_pend) begin
            checks++;
            if (!mem_req || mem_addr !== prev_addr || mem_we !== prev_we ||
                (prev_we && mem_wdata !== prev_wdata)) begin
                errors++;
                $display("FAIL beat_hold: req=%b addr=%h we=%b, required req=1 addr=%h we=%b",
                         mem_req, mem_addr, mem_we, prev_addr, prev_we);
            end
        end
        prev_pend  = mem_req && !mem_ack && !rst;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
        if (mem_req && mem_ack && !rst) begin
            log_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
            if (mem_we) mem[mem_addr] = mem_wdata;
            ack_total++;
            wait_cnt = 0;
        end
    end

    // ---------------- reference cache model ----------------
    logic [20:0] mru_t [64];
    logic [20:0] lru_t [64];
    int          cnt   [64];
    bit          dirty [logic [26:0]];

    task automatic model_reset();
        for (int s = 0; s < 64; s++) cnt[s] = 0;
        dirty.delete();
        ref_mem = mem;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int stalls, output int first);
        @(negedge clk);
        first = log_q.size();
        cpu_rd_en = rd; cpu_wr_en = wr; cpu_addr = addr; cpu_wdata = wdata;
        stalls = 0;
        #1;
        while (cpu_stall && stalls < 400) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (cpu_stall) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, stalls);
        end
        rdata = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    endtask

    task automatic check_beats(input string name, input int first, input int nwb,
                               input logic [31:0] wb_base, input int nrd,
                               input logic [31:0] rd_base);
        logic [31:0] ea;
        check({name, " beat_count"}, log_q.size() - first, nwb + nrd);
        for (int i = 0; i < nwb + nrd && first + i < log_q.size(); i++) begin
            ea = (i < nwb) ? wb_base + 4 * i : rd_base + 4 * (i - nwb);
            check($sformatf("%s beat%0d addr", name, i), log_q[first+i].addr, ea);
            check($sformatf("%s beat%0d we", name, i), {31'd0, log_q[first+i].we}, {31'd0, (i < nwb)});
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit rd; bit wr; logic [31:0] addr; logic [31:0] wdata;
        int stalls; bit chk_rd; logic [31:0] rdata;
        int nwb; logic [31:0] wb_base; int nrd; logic [31:0] rd_base;
        int wchk; logic [31:0] wchk_data;
    } vec_t;
    vec_t tbl[$];

    logic [31:0] rdata, base_line;
    int          stalls, first, cyc, base_ack;

    initial begin
        // Ack delay 1: clean miss = 1 + 8*2 = 17, dirty miss = 1 + 16*2 = 33.
        tbl.push_back('{1,0,32'h100, 0, 17, 1, init_word(32'h100), 0, 0, 8, 32'h100, -1, 0});
        tbl.push_back('{1,0,32'h104, 0,  0, 1, init_word(32'h104), 0, 0, 0, 0, -1, 0});
        tbl.push_back('{0,1,32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, -1, 0});
        tbl.push_back('{1,0,32'h900, 0, 17, 1, init_word(32'h900), 0, 0, 8, 32'h900, -1, 0});
        tbl.push_back('{1,0,32'h1100, 0, 33, 1, init_word(32'h1100), 8, 32'h100, 8, 32'h1100, 0, 32'hDEADBEEF});
        tbl.push_back('{1,0,32'h100, 0, 17, 1, 32'hDEADBEEF, 0, 0, 8, 32'h100, -1, 0});
        tbl.push_back('{1,0,32'h900, 0, 17, 1, init_word(32'h900), 0, 0, 8, 32'h900, -1, 0});
        tbl.push_back('{1,1,32'h904, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, -1, 0});
        tbl.push_back('{1,0,32'h1100, 0, 17, 1, init_word(32'h1100), 0, 0, 8, 32'h1100, -1, 0});
        tbl.push_back('{1,0,32'h100, 0, 33, 1, 32'hDEADBEEF, 8, 32'h900, 8, 32'h100, 1, 32'h12345678});
        tbl.push_back('{1,0,32'h904, 0, 17, 1, 32'h12345678, 0, 0, 8, 32'h900, -1, 0});
        tbl.push_back('{1,0,32'h11C, 0,  0, 1, init_word(32'h11C), 0, 0, 0, 0, -1, 0});

        // Reset state
        reset_all();
        #1;
        check("reset cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);

        ack_delay = 1;
        foreach (tbl[i]) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rdata, stalls, first);
            check($sformatf("v%0d stalls", i), stalls, tbl[i].stalls);
            if (tbl[i].chk_rd) check($sformatf("v%0d rdata", i), rdata, tbl[i].rdata);
            check_beats($sformatf("v%0d", i), first, tbl[i].nwb, tbl[i].wb_base,
                        tbl[i].nrd, tbl[i].rd_base);
            if (tbl[i].wchk >= 0 && first + tbl[i].wchk < log_q.size())
                check($sformatf("v%0d wb_data", i), log_q[first+tbl[i].wchk].data, tbl[i].wchk_data);
        end

        // Ack withheld 5 extra cycles on beat 2 of a refill
        ack_delay = 0;
        hold_at   = ack_total + 2;
        access(1, 0, 32'h40, 0, rdata, stalls, first);
        hold_at   = -1;
        check("hold stalls", stalls, 1 + 8 + 5);
        check("hold rdata", rdata, init_word(32'h40));
        check_beats("hold", first, 0, 0, 8, 32'h40);

        // Reset during write-back beat 3
        ack_delay = 1;
        reset_all();
        access(0, 1, 32'h100, 32'hDEADBEEF, rdata, stalls, first);
        access(1, 0, 32'h900, 0, rdata, stalls, first);
        @(negedge clk);
        base_ack = ack_total;
        first    = log_q.size();
        cpu_rd_en = 1'b1; cpu_addr = 32'h1100;
        cyc = 0;
        while (ack_total < base_ack + 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rstwb in_wback", {31'd0, mem_req & mem_we}, 32'd1);
        check("rstwb beat3 addr", mem_addr, 32'h10C);
        rst = 1'b1; cpu_rd_en = 1'b0;
        @(posedge clk);
        #1;
        check("rstwb mem_req_drop", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check("rstwb no_more_beats", ack_total - base_ack, 3);
        check("rstwb idle mem_req", {31'd0, mem_req}, 32'd0);
        check("rstwb idle stall", {31'd0, cpu_stall}, 32'd0);
        access(1, 0, 32'h100, 0, rdata, stalls, first);
        check("rstwb reread stalls", stalls, 17);
        check("rstwb reread data", rdata, 32'hDEADBEEF);

        // Randomized accesses against the reference model
        reset_all();
        for (int n = 0; n < 80; n++) begin
            logic [20:0] tags [4];
            logic [20:0] t;
            logic [5:0]  s;
            logic [31:0] addr, wa, wd, exp_rd, wb_base;
            logic [26:0] vline;
            bit          rd, wr, hit;
            int          op, nwb, nrd, exp_st;
            tags[0] = 21'h0; tags[1] = 21'h1; tags[2] = 21'h155; tags[3] = 21'h1FFFFF;
            ack_delay = $urandom_range(0, 2);
            t  = tags[$urandom_range(0, 3)];
            s  = ($urandom_range(0, 1) != 0) ? 6'd3 : 6'd40;
            addr = {t, s, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            wa   = {addr[31:2], 2'b00};
            op = $urandom_range(0, 3);
            rd = (op != 2);
            wr = (op >= 2);
            wd = $urandom;
            nwb = 0; nrd = 0; wb_base = '0;
            hit = 1'b0;
            if (cnt[s] > 0 && mru_t[s] == t) begin
                hit = 1'b1;
            end else if (cnt[s] == 2 && lru_t[s] == t) begin
                hit = 1'b1;
                lru_t[s] = mru_t[s];
                mru_t[s] = t;
            end else begin
                nrd = 8;
                if (cnt[s] < 2) begin
                    if (cnt[s] == 1) lru_t[s] = mru_t[s];
                    cnt[s]++;
                end else begin
                    vline = {lru_t[s], s};
                    if (dirty.exists(vline)) begin
                        nwb = 8;
                        wb_base = {vline, 5'b0};
                        dirty.delete(vline);
                    end
                    lru_t[s] = mru_t[s];
                end
                mru_t[s] = t;
            end
            exp_st = hit ? 0 : 1 + (nwb + nrd) * (ack_delay + 1);
            exp_rd = ref_rd(wa);
            access(rd, wr, addr, wd, rdata, stalls, first);
            check($sformatf("r%0d stalls", n), stalls, exp_st);
            if (!wr) check($sformatf("r%0d rdata", n), rdata, exp_rd);
            check_beats($sformatf("r%0d", n), first, nwb, wb_base, nrd, {addr[31:5], 5'b0});
            for (int i = 0; i < nwb && first + i < log_q.size(); i++)
                check($sformatf("r%0d wb%0d data", n, i), log_q[first+i].data, ref_rd(wb_base + 4 * i));
            if (wr) begin
                ref_mem[wa] = wd;
                dirty[addr[31:5]] = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
